sync_mem: RTL and testbench
===========================

# sync_mem

Single-port synchronous RAM with a parameterised data/address width and 2^N words. One write or one read per clock, registered read data, and a per-word "written since reset" flag. General-purpose storage element used by datapath blocks that need small register-file style memories.

## Interface

Parameters:
- N, default 4: data width and address width in bits; depth = 2^N words.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- out  output  N  registered read data.
- vld  output  1  registered flag: the word read into `out` has been written since reset.
- in  input  N  write data.
- address  input  N  word address for both write and read.
- we  input  1  write enable, active-high.

## Operation

- Storage: 2^N words of N bits, plus a 2^N-bit written bitmap.
- Reset, when rst_n=0 at a rising edge:
  - all words <= 0;
  - bitmap <= 0;
  - out <= 0 and vld <= 0.
  - Reset overrides we; no write occurs during a reset cycle.
- Write, when rst_n=1 and we=1:
  - mem[address] <= in;
  - bitmap[address] <= 1.
- Read: every non-reset cycle, regardless of we, out <= mem[address] and vld <= bitmap[address].
- Read-during-write to the same address is read-first by default: out and vld take the pre-write contents. See Configuration.
- we=0: memory and bitmap are unchanged, so `in` is ignored.
- Every address 0..2^N-1 is valid. The full N-bit address space is used, so there is no out-of-range case.
- X/Z on `address` or `we` while rst_n=1 is not supported. Behaviour is undefined.

## Timing

- Write latency: data is stored at the rising edge where we=1. A read of that address issued on the following edge returns it.
- Read latency: 1 cycle. `out` and `vld` reflect the `address` sampled at edge k, and are valid after edge k.
- `out` and `vld` hold their value between edges. There is no combinational path from inputs to outputs in the default build.
- Back-to-back writes to the same address: the last one wins.
- Reset mid-operation: a write in the same cycle as rst_n=0 is discarded. In the cycle after reset deasserts, out=0 and vld=0 until the first read edge.

## Configuration

- SYNC_MEM_WRITE_THROUGH_EN undefined (default): read-first. On a write cycle, out <= old mem[address] and vld <= old bitmap[address].
- SYNC_MEM_WRITE_THROUGH_EN defined: write-first. On a write cycle, out <= in and vld <= 1. Read latency, reset and all other behaviour are unchanged, and outputs remain registered.

## Structure

- Package sync_mem_pkg:
  - localparam default width 4;
  - function returning depth (1 << N).
- Keep everything else local to the module.
- Single module; no sub-module is warranted. The array, bitmap and output registers form one always block plus the read mux.

## Test plan

- Reset then read: rst_n=0 for 2 cycles, then read address 0..15 -> out=0 and vld=0 for every address.
- Basic write/read, N=4: we=1, address=3, in=8 for 1 edge; then we=0, address=3 -> out=8 and vld=1 one edge later.
- Write inhibited: after the previous step, we=0, address=3, in=15 -> out stays 8, mem[3] remains 8. A later read of address 3 returns 8.
- Read-during-write: mem[3]=8, then we=1, address=3, in=5:
  - default build -> out=8 that cycle, then 5 on the next read;
  - with SYNC_MEM_WRITE_THROUGH_EN -> out=5 immediately.
- Full sweep: write in=address^4'hA to all 16 addresses, then read all -> each out matches its pattern and vld=1. Addresses 0 and 15 must be covered.
- Reset mid-operation: fill addresses 0..15, then assert rst_n=0 while we=1, address=7, in=9 -> after reset, every read returns out=0, vld=0, and address 7 is not written.

Source files
------------

// File: rtl/sync_mem_pkg.sv
// ============================================================================
// Module      : sync_mem_pkg
// Description : Shared constants and helpers for the sync_mem RAM.
//               DEFAULT_WIDTH  - default data/address width in bits
//               sync_mem_depth - number of words for a given address width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_mem_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int sync_mem_depth(input int n);
    return 1 << n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_mem.sv
// ============================================================================
// Module      : sync_mem
// Description : Single-port synchronous RAM, 2^N words of N bits, with a
//               registered read port and a per-word "written since reset"
//               flag. One write or one read per clock.
//
// Ports       : clk     - clock, all updates on the rising edge
//               rst_n   - synchronous active-low reset (clears words,
//                         flags and outputs; overrides we)
//               in      - write data (N bits)
//               address - word address for both write and read (N bits)
//               we      - write enable, active-high
//               out     - registered read data (N bits)
//               vld     - registered flag: word read into out was written
//                         since reset
//
// Config      : SYNC_MEM_WRITE_THROUGH_EN
//               undefined - read-first on a same-cycle write
//               defined   - write-first: out <= in, vld <= 1 on a write
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_mem
  import sync_mem_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] out,
  output logic         vld,
  input  logic [N-1:0] in,
  input  logic [N-1:0] address,
  input  logic         we
);

  localparam int DEPTH = sync_mem_depth(N);

  logic [N-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] written;

  // Read mux: the value that will be registered into out/vld this edge.
  logic [N-1:0] rd_data;
  logic         rd_vld;

  always_comb begin
    rd_data = mem[address];
    rd_vld  = written[address];
`ifdef SYNC_MEM_WRITE_THROUGH_EN
    // Write-first: a write forwards its own data to the read port.
    if (we) begin
      rd_data = in;
      rd_vld  = 1'b1;
    end
`endif
  end

  // Array, written-bitmap and output registers share one process so the
  // reset clears everything in the same edge and blocks any write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      written <= '0;
      out     <= '0;
      vld     <= 1'b0;
    end else begin
      if (we) begin
        mem[address]     <= in;
        written[address] <= 1'b1;
      end
      out <= rd_data;
      vld <= rd_vld;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_mem.sv
// ============================================================================
// Module      : tb_sync_mem
// Description : Self-checking bench for sync_mem (N=4). Directed vectors
//               with hand-computed expected out/vld, plus hand-written
//               sequences for output hold and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_mem;

  logic       clk;
  logic       rst_n;
  logic [3:0] out;
  logic       vld;
  logic [3:0] in;
  logic [3:0] address;
  logic       we;

  int checks   = 0;
  int failures = 0;

  sync_mem #(.N(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .out     (out),
    .vld     (vld),
    .in      (in),
    .address (address),
    .we      (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       we;
    logic [3:0] addr;
    logic [3:0] din;
    logic [3:0] exp_out;
    logic       exp_vld;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic r, input logic w,
                              input logic [3:0] a, input logic [3:0] d,
                              input logic [3:0] eo, input logic ev);
    vec_t v;
    v.name = name; v.rst_n = r; v.we = w; v.addr = a; v.din = d;
    v.exp_out = eo; v.exp_vld = ev;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] got_out,
                       input logic got_vld, input logic [3:0] e_out,
                       input logic e_vld);
    checks++;
    if (got_out !== e_out || got_vld !== e_vld) begin
      failures++;
      $display("FAIL %s: out=%h vld=%b, required out=%h vld=%b",
               name, got_out, got_vld, e_out, e_vld);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample #1 after the edge.
  task automatic apply(input logic r, input logic w, input logic [3:0] a,
                       input logic [3:0] d);
    rst_n = r; we = w; address = a; in = d;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] held;

  initial begin
    rst_n = 1'b0; we = 1'b0; address = '0; in = '0;

    // ---------------- vector table ----------------
    // Reset for two cycles with a write attempted: no effect.
    add("reset0", 1'b0, 1'b1, 4'd0, 4'd5, 4'h0, 1'b0);
    add("reset1", 1'b0, 1'b1, 4'd0, 4'd5, 4'h0, 1'b0);
    for (int a = 0; a < 16; a++)
      add($sformatf("rst_rd%0d", a), 1'b1, 1'b0, 4'(a), 4'hF, 4'h0, 1'b0);

    // Basic write then read of address 3.
`ifdef SYNC_MEM_WRITE_THROUGH_EN
    add("wr3_8",   1'b1, 1'b1, 4'd3, 4'd8, 4'h8, 1'b1);
`else
    add("wr3_8",   1'b1, 1'b1, 4'd3, 4'd8, 4'h0, 1'b0);
`endif
    add("rd3",     1'b1, 1'b0, 4'd3, 4'd0, 4'h8, 1'b1);
    // Write inhibited: in=15 with we=0 must not land.
    add("inh3",    1'b1, 1'b0, 4'd3, 4'hF, 4'h8, 1'b1);
    add("inh3_rd", 1'b1, 1'b0, 4'd3, 4'h0, 4'h8, 1'b1);
    // Read-during-write on address 3.
`ifdef SYNC_MEM_WRITE_THROUGH_EN
    add("rdw3",    1'b1, 1'b1, 4'd3, 4'd5, 4'h5, 1'b1);
`else
    add("rdw3",    1'b1, 1'b1, 4'd3, 4'd5, 4'h8, 1'b1);
`endif
    add("rdw3_rd", 1'b1, 1'b0, 4'd3, 4'd0, 4'h5, 1'b1);

    // Full sweep write of address^A; read-first sees old contents
    // (only address 3 was written, holding 5).
    for (int a = 0; a < 16; a++) begin
`ifdef SYNC_MEM_WRITE_THROUGH_EN
      add($sformatf("sw_wr%0d", a), 1'b1, 1'b1, 4'(a), 4'(a) ^ 4'hA,
          4'(a) ^ 4'hA, 1'b1);
`else
      add($sformatf("sw_wr%0d", a), 1'b1, 1'b1, 4'(a), 4'(a) ^ 4'hA,
          (a == 3) ? 4'h5 : 4'h0, (a == 3));
`endif
    end
    for (int a = 0; a < 16; a++)
      add($sformatf("sw_rd%0d", a), 1'b1, 1'b0, 4'(a), 4'h0,
          4'(a) ^ 4'hA, 1'b1);

    // Back-to-back writes to address 5 (holds 5^A=F): last one wins.
`ifdef SYNC_MEM_WRITE_THROUGH_EN
    add("b2b_w1", 1'b1, 1'b1, 4'd5, 4'd1, 4'h1, 1'b1);
    add("b2b_w2", 1'b1, 1'b1, 4'd5, 4'd2, 4'h2, 1'b1);
`else
    add("b2b_w1", 1'b1, 1'b1, 4'd5, 4'd1, 4'hF, 1'b1);
    add("b2b_w2", 1'b1, 1'b1, 4'd5, 4'd2, 4'h1, 1'b1);
`endif
    add("b2b_rd", 1'b1, 1'b0, 4'd5, 4'd0, 4'h2, 1'b1);

    // Reset mid-operation with a write to 7 pending: discarded.
    add("mid_rst", 1'b0, 1'b1, 4'd7, 4'd9, 4'h0, 1'b0);
    for (int a = 0; a < 16; a++)
      add($sformatf("post_rst_rd%0d", a), 1'b1, 1'b0, 4'(a), 4'h0,
          4'h0, 1'b0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].we, vecs[i].addr, vecs[i].din);
      check(vecs[i].name, out, vld, vecs[i].exp_out, vecs[i].exp_vld);
    end

    // ---------------- hand-written sequences ----------------
    // Outputs hold between edges: write 0xC to 9, read it, then move
    // address/we mid-cycle and confirm out/vld do not follow.
    apply(1'b1, 1'b1, 4'd9, 4'hC);
    apply(1'b1, 1'b0, 4'd9, 4'h0);
    check("hold_rd9", out, vld, 4'hC, 1'b1);
    held = out;
    address = 4'd2; we = 1'b1; in = 4'h6;
    #3;
    check("hold_mid", out, vld, held, 1'b1);
    @(posedge clk); #1;   // this edge writes 6 into address 2
`ifdef SYNC_MEM_WRITE_THROUGH_EN
    check("hold_wr2", out, vld, 4'h6, 1'b1);
`else
    check("hold_wr2", out, vld, 4'h0, 1'b0);
`endif
    apply(1'b1, 1'b0, 4'd2, 4'h0);
    check("hold_rd2", out, vld, 4'h6, 1'b1);

    // Reset clears a previously read value; outputs stay 0 in the
    // following idle cycle until a read edge brings new data.
    apply(1'b0, 1'b0, 4'd2, 4'h0);
    check("rst2_out", out, vld, 4'h0, 1'b0);
    rst_n = 1'b1; address = 4'd9;
    #3;
    check("rst2_idle", out, vld, 4'h0, 1'b0);
    @(posedge clk); #1;
    check("rst2_rd9", out, vld, 4'h0, 1'b0);
    apply(1'b1, 1'b1, 4'd15, 4'h3);
    apply(1'b1, 1'b0, 4'd15, 4'h0);
    check("rst2_rd15", out, vld, 4'h3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
